// File: rtl/ttt_move_if.sv
// Move-request and game-state bundle between the input conditioner, the move
// engine and the downstream display path.
interface ttt_move_if;
  logic [3:0]  cell_sel;
  logic        place;
  logic        new_game;
  logic [17:0] board;
  logic        turn;
  logic        move_ok;
  logic        move_err;
  logic [1:0]  winner;
  logic [7:0]  win_line;
  logic        game_over;

  modport master (
    output cell_sel, place, new_game,
    input  board, turn, move_ok, move_err, winner, win_line, game_over
  );

  modport slave (
    input  cell_sel, place, new_game,
    output board, turn, move_ok, move_err, winner, win_line, game_over
  );
endinterface

// File: rtl/ttt_move_engine.sv
// Tic-tac-toe game logic: holds the board, alternates turns, rejects illegal
// moves and reports win/draw with the completed lines.
//
// state | meaning
// PLAY  | waiting for a move from the player in turn
// CHECK | evaluating the board after an accepted move
// OVER  | game decided; moves are rejected until new_game
module ttt_move_engine #(
  parameter logic FIRST_PLAYER = 1'b0
) (
  input logic       clk,
  input logic       rst,
  ttt_move_if.slave mv
);

  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    CHECK = 2'd1,
    OVER  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [17:0] board_q, board_d;
  logic        turn_q, turn_d;
  logic [3:0]  count_q, count_d;
  logic [1:0]  winner_q, winner_d;
  logic [7:0]  win_line_q, win_line_d;
  logic        game_over_q, game_over_d;
  logic        move_ok_q, move_ok_d;
  logic        move_err_q, move_err_d;

  logic [3:0]  cell_idx;
  logic [4:0]  bit_idx;
  logic        cell_valid;
  logic        cell_empty;
  logic        move_legal;
  logic [1:0]  mover_code;
  logic [7:0]  mover_lines;

  // Lines fully held by player code p.
  function automatic logic [7:0] lines_of(input logic [17:0] b, input logic [1:0] p);
    logic [8:0] m;
    logic [7:0] l;
    for (int i = 0; i < 9; i++) begin
      m[i] = (b[2*i +: 2] == p);
    end
    l[0] = m[0] & m[1] & m[2];
    l[1] = m[3] & m[4] & m[5];
    l[2] = m[6] & m[7] & m[8];
    l[3] = m[0] & m[3] & m[6];
    l[4] = m[1] & m[4] & m[7];
    l[5] = m[2] & m[5] & m[8];
    l[6] = m[0] & m[4] & m[8];
    l[7] = m[2] & m[4] & m[6];
    return l;
  endfunction

  // Out-of-range selects are steered to cell 0 so the read never leaves the board.
  assign cell_valid  = (mv.cell_sel <= 4'd8);
  assign cell_idx    = cell_valid ? mv.cell_sel : 4'd0;
  assign bit_idx     = {cell_idx, 1'b0};
  assign cell_empty  = (board_q[bit_idx +: 2] == 2'b00);
  assign move_legal  = cell_valid && cell_empty;
  assign mover_code  = turn_q ? 2'b10 : 2'b01;
  assign mover_lines = lines_of(board_q, mover_code);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= PLAY;
      board_q     <= '0;
      turn_q      <= FIRST_PLAYER;
      count_q     <= '0;
      winner_q    <= 2'b00;
      win_line_q  <= '0;
      game_over_q <= 1'b0;
      move_ok_q   <= 1'b0;
      move_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      board_q     <= board_d;
      turn_q      <= turn_d;
      count_q     <= count_d;
      winner_q    <= winner_d;
      win_line_q  <= win_line_d;
      game_over_q <= game_over_d;
      move_ok_q   <= move_ok_d;
      move_err_q  <= move_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (mv.new_game) begin
      state_d = PLAY;
    end else begin
      case (state_q)
        PLAY:    if (mv.place && move_legal) state_d = CHECK;
        CHECK:   if ((|mover_lines) || (count_q == 4'd9)) state_d = OVER;
                 else state_d = PLAY;
        OVER:    state_d = OVER;
        default: state_d = PLAY;
      endcase
    end
  end

  always_comb begin
    board_d     = board_q;
    turn_d      = turn_q;
    count_d     = count_q;
    winner_d    = winner_q;
    win_line_d  = win_line_q;
    game_over_d = game_over_q;
    move_ok_d   = 1'b0;
    move_err_d  = 1'b0;
    if (mv.new_game) begin
      board_d     = '0;
      turn_d      = FIRST_PLAYER;
      count_d     = '0;
      winner_d    = 2'b00;
      win_line_d  = '0;
      game_over_d = 1'b0;
    end else begin
      case (state_q)
        PLAY: begin
          if (mv.place) begin
            if (move_legal) begin
              board_d[bit_idx +: 2] = mover_code;
              count_d   = count_q + 4'd1;
              move_ok_d = 1'b1;
            end else begin
              move_err_d = 1'b1;
            end
          end
        end
        CHECK: begin
          // A win on the final move outranks the draw.
          if (|mover_lines) begin
            winner_d    = mover_code;
            win_line_d  = mover_lines;
            game_over_d = 1'b1;
          end else if (count_q == 4'd9) begin
            winner_d    = 2'b11;
            win_line_d  = '0;
            game_over_d = 1'b1;
          end else begin
            turn_d = ~turn_q;
          end
        end
        OVER: begin
          if (mv.place) move_err_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign mv.board     = board_q;
  assign mv.turn      = turn_q;
  assign mv.move_ok   = move_ok_q;
  assign mv.move_err  = move_err_q;
  assign mv.winner    = winner_q;
  assign mv.win_line  = win_line_q;
  assign mv.game_over = game_over_q;

endmodule

// File: tb/tb_ttt_move_engine.sv
// Directed bench for ttt_move_engine: reset, wins, draw, illegal moves,
// restart priority and asynchronous reset.
module tb_ttt_move_engine;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_err;

  ttt_move_if mv ();

  ttt_move_engine #(.FIRST_PLAYER(1'b0)) dut (
    .clk (clk),
    .rst (rst),
    .mv  (mv)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One move: request at a falling edge, capture the pulse one cycle later,
  // then let the CHECK cycle pass.
  task automatic do_move(input logic [3:0] c, output logic ok, output logic err);
    @(negedge clk);
    mv.cell_sel = c;
    mv.place    = 1'b1;
    @(negedge clk);
    ok       = mv.move_ok;
    err      = mv.move_err;
    mv.place = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_new_game();
    @(negedge clk);
    mv.new_game = 1'b1;
    @(negedge clk);
    mv.new_game = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mv.cell_sel = 4'd0;
    mv.place    = 1'b0;
    mv.new_game = 1'b0;
    #1;
    n_checks++;
    if (mv.board !== 18'h0) begin n_err++; $display("FAIL reset_board got=%h exp=0", mv.board); end
    n_checks++;
    if (mv.turn !== 1'b0) begin n_err++; $display("FAIL reset_turn got=%b exp=0", mv.turn); end
    n_checks++;
    if (mv.winner !== 2'b00 || mv.game_over !== 1'b0) begin
      n_err++; $display("FAIL reset_result winner=%b game_over=%b exp=00/0", mv.winner, mv.game_over);
    end
    n_checks++;
    if (mv.move_ok !== 1'b0 || mv.move_err !== 1'b0) begin
      n_err++; $display("FAIL reset_pulses ok=%b err=%b exp=0/0", mv.move_ok, mv.move_err);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_row_a_win();
    logic [3:0] cells [5] = '{4'd0, 4'd3, 4'd1, 4'd4, 4'd2};
    logic ok, err;
    int   n_ok;
    n_ok = 0;
    do_new_game();
    for (int i = 0; i < 5; i++) begin
      do_move(cells[i], ok, err);
      if (ok === 1'b1 && err === 1'b0) n_ok++;
    end
    n_checks++;
    if (n_ok !== 5) begin n_err++; $display("FAIL rowa_ok_count got=%0d exp=5", n_ok); end
    n_checks++;
    if (mv.winner !== 2'b01) begin n_err++; $display("FAIL rowa_winner got=%b exp=01", mv.winner); end
    n_checks++;
    if (mv.win_line !== 8'h01) begin n_err++; $display("FAIL rowa_win_line got=%h exp=01", mv.win_line); end
    n_checks++;
    if (mv.game_over !== 1'b1) begin n_err++; $display("FAIL rowa_game_over got=%b exp=1", mv.game_over); end
    n_checks++;
    if (mv.board !== 18'h00295) begin n_err++; $display("FAIL rowa_board got=%h exp=00295", mv.board); end
    do_move(4'd8, ok, err);
    n_checks++;
    if (ok !== 1'b0 || err !== 1'b1) begin n_err++; $display("FAIL rowa_over_place ok=%b err=%b exp=0/1", ok, err); end
    n_checks++;
    if (mv.board !== 18'h00295) begin n_err++; $display("FAIL rowa_over_board got=%h exp=00295", mv.board); end
  endtask

  task automatic test_async_reset();
    // Engine is in OVER from the previous scenario.
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (mv.board !== 18'h0 || mv.winner !== 2'b00 || mv.game_over !== 1'b0 || mv.win_line !== 8'h00) begin
      n_err++;
      $display("FAIL async_rst board=%h winner=%b over=%b line=%h exp=0/00/0/00",
               mv.board, mv.winner, mv.game_over, mv.win_line);
    end
    #1 rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_illegal();
    logic ok, err;
    do_new_game();
    do_move(4'd0, ok, err);
    n_checks++;
    if (ok !== 1'b1 || mv.turn !== 1'b1) begin n_err++; $display("FAIL ill_first ok=%b turn=%b exp=1/1", ok, mv.turn); end
    do_move(4'd0, ok, err);
    n_checks++;
    if (ok !== 1'b0 || err !== 1'b1) begin n_err++; $display("FAIL ill_occupied ok=%b err=%b exp=0/1", ok, err); end
    n_checks++;
    if (mv.turn !== 1'b1) begin n_err++; $display("FAIL ill_turn_hold got=%b exp=1", mv.turn); end
    do_move(4'd12, ok, err);
    n_checks++;
    if (ok !== 1'b0 || err !== 1'b1) begin n_err++; $display("FAIL ill_range ok=%b err=%b exp=0/1", ok, err); end
    n_checks++;
    if (mv.board !== 18'h00001) begin n_err++; $display("FAIL ill_range_board got=%h exp=00001", mv.board); end
    // Accepted move, then a second request arriving during CHECK.
    @(negedge clk);
    mv.cell_sel = 4'd1;
    mv.place    = 1'b1;
    @(negedge clk);
    n_checks++;
    if (mv.move_ok !== 1'b1) begin n_err++; $display("FAIL ill_pre_check ok=%b exp=1", mv.move_ok); end
    mv.cell_sel = 4'd2;
    @(negedge clk);
    mv.place = 1'b0;
    n_checks++;
    if (mv.move_ok !== 1'b0 || mv.move_err !== 1'b0) begin
      n_err++; $display("FAIL ill_check_drop ok=%b err=%b exp=0/0", mv.move_ok, mv.move_err);
    end
    n_checks++;
    if (mv.board !== 18'h00009 || mv.turn !== 1'b0) begin
      n_err++; $display("FAIL ill_check_board board=%h turn=%b exp=00009/0", mv.board, mv.turn);
    end
  endtask

  task automatic test_draw();
    logic [3:0] cells [9] = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd3, 4'd5, 4'd7, 4'd6, 4'd8};
    logic ok, err;
    int   n_ok;
    n_ok = 0;
    do_new_game();
    for (int i = 0; i < 9; i++) begin
      do_move(cells[i], ok, err);
      if (ok === 1'b1) n_ok++;
    end
    n_checks++;
    if (n_ok !== 9) begin n_err++; $display("FAIL draw_ok_count got=%0d exp=9", n_ok); end
    n_checks++;
    if (mv.winner !== 2'b11 || mv.win_line !== 8'h00 || mv.game_over !== 1'b1) begin
      n_err++; $display("FAIL draw_result winner=%b line=%h over=%b exp=11/00/1", mv.winner, mv.win_line, mv.game_over);
    end
    n_checks++;
    if (mv.board !== 18'h16A59 || mv.turn !== 1'b0) begin
      n_err++; $display("FAIL draw_board board=%h turn=%b exp=16a59/0", mv.board, mv.turn);
    end
    do_move(4'd0, ok, err);
    n_checks++;
    if (ok !== 1'b0 || err !== 1'b1) begin n_err++; $display("FAIL draw_extra ok=%b err=%b exp=0/1", ok, err); end
  endtask

  task automatic test_double_line();
    logic [3:0] cells [9] = '{4'd1, 4'd4, 4'd2, 4'd5, 4'd3, 4'd7, 4'd6, 4'd8, 4'd0};
    logic ok, err;
    int   n_ok;
    n_ok = 0;
    do_new_game();
    for (int i = 0; i < 9; i++) begin
      do_move(cells[i], ok, err);
      if (ok === 1'b1) n_ok++;
    end
    n_checks++;
    if (n_ok !== 9) begin n_err++; $display("FAIL dbl_ok_count got=%0d exp=9", n_ok); end
    n_checks++;
    if (mv.winner !== 2'b01 || mv.win_line !== 8'h09) begin
      n_err++; $display("FAIL dbl_result winner=%b line=%h exp=01/09", mv.winner, mv.win_line);
    end
  endtask

  task automatic test_new_game_priority();
    logic ok, err;
    do_new_game();
    do_move(4'd0, ok, err);
    do_move(4'd4, ok, err);
    n_checks++;
    if (mv.board !== 18'h00201 || mv.turn !== 1'b0) begin
      n_err++; $display("FAIL ng_setup board=%h turn=%b exp=00201/0", mv.board, mv.turn);
    end
    @(negedge clk);
    mv.new_game = 1'b1;
    mv.place    = 1'b1;
    mv.cell_sel = 4'd1;
    @(negedge clk);
    n_checks++;
    if (mv.board !== 18'h0 || mv.move_ok !== 1'b0 || mv.move_err !== 1'b0 || mv.turn !== 1'b0) begin
      n_err++;
      $display("FAIL ng_priority board=%h ok=%b err=%b turn=%b exp=0/0/0/0",
               mv.board, mv.move_ok, mv.move_err, mv.turn);
    end
    mv.new_game = 1'b0;
    mv.place    = 1'b0;
    do_move(4'd8, ok, err);
    n_checks++;
    if (ok !== 1'b1 || mv.board !== 18'h10000) begin
      n_err++; $display("FAIL ng_after ok=%b board=%h exp=1/10000", ok, mv.board);
    end
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    test_reset();
    test_row_a_win();
    test_async_reset();
    test_illegal();
    test_draw();
    test_double_line();
    test_new_game_priority();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout sim_time=%0t limit=200000", $time);
    $fatal(1, "timeout");
  end
endmodule
